dmem_line_responder: RTL and testbench
======================================

Name: dmem_line_responder

Overview:
- Memory-side responder for the Aquila cache-line data-memory port (strobe/addr/rw/data/done). It serves full-line reads and writes from an on-chip word-wide SRAM.
- Each line is moved as CLSIZE/XLEN sequential word beats, with a programmable access latency in front of the transfer.
- Used as the DMEM target in simulation and small-FPGA builds without DDRx. It connects directly to the processor wrapper's M_DMEM_* outputs.

Parameters:
- XLEN, 32, word width in bits.
- CLSIZE, 256, cache-line width in bits; must be a multiple of XLEN.
- MEM_WORDS, 16384, SRAM depth in XLEN-bit words; power of two and a multiple of N_BEATS.
- LAT_WAIT, 4, idle cycles inserted between request accept and first beat (>=0).
- Derived: N_BEATS = CLSIZE/XLEN; OFS_BITS = log2(CLSIZE/8); IDX_BITS = log2(MEM_WORDS).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- S_DMEM_strobe_i  in  1  request strobe; held high by requestor until done seen
- S_DMEM_addr_i  in  XLEN  byte address of line
- S_DMEM_rw_i  in  1  1=write line, 0=read line
- S_DMEM_data_i  in  CLSIZE  write line data
- S_DMEM_done_o  out  1  one-cycle completion pulse
- S_DMEM_data_o  out  CLSIZE  read line data
- busy_o  out  1  high from accept through done cycle

Behaviour:
- Reset (rst_i sampled high at clock edge):
  - state=IDLE; done_o=0, data_o=0, busy_o=0; strobe_q=0; counters cleared.
  - SRAM contents are not cleared.
- Accept: in IDLE, when strobe_i=1 and strobe_q=0 (rising edge), latch addr, rw, data_i. strobe_q is the registered strobe_i.
- A strobe held high across done does not re-trigger; the requestor must drop strobe for at least one cycle between requests.
- Strobe rises while not IDLE: ignored.
- Line index: word base = {addr[OFS_BITS+IDX_BITS-log2(N_BEATS)-1 : OFS_BITS], beat}.
  - Byte-offset bits below OFS_BITS are ignored (line-aligned).
  - Address bits above the SRAM range are ignored, so accesses wrap modulo MEM_WORDS.
- Beat order: beat k maps to line bits [k*XLEN +: XLEN], k=0..N_BEATS-1, ascending.
- SRAM: single-port, synchronous read with 1-cycle latency, full-word write (no byte enables).
- FSM states: IDLE -> WAIT -> XFER -> (RDLAST if read) -> DONE -> IDLE.
  - WAIT: counts LAT_WAIT cycles. When LAT_WAIT=0 it passes through in 1 cycle; WAIT always lasts max(LAT_WAIT,1) cycles.
  - XFER: N_BEATS cycles, one SRAM access per cycle, beat counter 0..N_BEATS-1.
    - Write stores data_i slice k at word k.
    - Read issues address k; the returned word lands in data_o slice k-1.
  - RDLAST (read only): captures the final word into slice N_BEATS-1.
  - DONE: done_o=1 for exactly one cycle; busy_o falls the following cycle.
- Latency, with accept at edge T:
  - Read: done high in cycle T+max(LAT_WAIT,1)+N_BEATS+2.
  - Write: done high in cycle T+max(LAT_WAIT,1)+N_BEATS+1.
  - Defaults: read 14, write 13.
- data_o:
  - On a read, updated slice-by-slice during XFER/RDLAST; fully valid when done=1.
  - Holds its value until the next read's first capture.
  - Writes never modify data_o.
- Read of a line whose write completed earlier returns the written data; there is no buffering hazard because requests are serialized.
- Reset mid-operation aborts immediately: no done pulse, return to IDLE. Words already written stay written; remaining beats are not written.
- done_o never asserts without a preceding accept.

Test Plan:
- Write line addr 0x8000_0040, data words 0x11111111..0x88888888 (beat0=0x11111111), then read same addr -> read done pulse; data_o bits[31:0]=0x11111111, bits[255:224]=0x88888888.
- Latency, LAT_WAIT=4: read accepted at cycle 0 -> done exactly at cycle 14, width 1. Write -> done at cycle 13. Repeat with LAT_WAIT=0: read 11, write 10.
- Hold strobe high for 40 cycles after one read -> exactly one done pulse. Drop strobe 1 cycle, raise again -> second done pulse.
- Address wrap, MEM_WORDS=16384: write line at 0x8000_0000, read 0x8001_0000 -> identical data. Read 0x8000_001C (unaligned) -> returns line 0x8000_0000.
- Issue write of all-0xA5 line at 0x100 over old all-0 line; assert rst_i for 1 cycle during beat 3 -> no done pulse, outputs zero, FSM IDLE. Subsequent read of 0x100 -> words 0..2 = 0xA5A5A5A5, words 4..7 = 0.
- Strobe rising while busy (second pulse mid-XFER) -> ignored; only one done pulse. Back-to-back requests with 1 idle cycle complete in order with correct data.

Source files
------------

// File: rtl/dmem_line_responder.sv
// Cache-line DMEM responder: serves full-line reads/writes from an on-chip
// word-wide SRAM as N_BEATS sequential word beats after a fixed access latency.
module dmem_line_responder #(
    parameter int XLEN      = 32,
    parameter int CLSIZE    = 256,
    parameter int MEM_WORDS = 16384,
    parameter int LAT_WAIT  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              S_DMEM_strobe_i,
    input  logic [XLEN-1:0]   S_DMEM_addr_i,
    input  logic              S_DMEM_rw_i,
    input  logic [CLSIZE-1:0] S_DMEM_data_i,
    output logic              S_DMEM_done_o,
    output logic [CLSIZE-1:0] S_DMEM_data_o,
    output logic              busy_o
);

    localparam int N_BEATS   = CLSIZE / XLEN;
    localparam int BEAT_BITS = $clog2(N_BEATS);
    localparam int OFS_BITS  = $clog2(CLSIZE / 8);
    localparam int IDX_BITS  = $clog2(MEM_WORDS);
    localparam int WAIT_CYC  = (LAT_WAIT > 0) ? LAT_WAIT : 1;
    localparam int CNT_MAX   = (WAIT_CYC > N_BEATS) ? WAIT_CYC : N_BEATS;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_RDLAST,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_strobe_q;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_BITS-1:0] r_base;
    logic                r_rw;
    logic [CLSIZE-1:0]   r_wdata;
    logic [CLSIZE-1:0]   r_rdline;
    logic [XLEN-1:0]     r_rdata;
    logic [XLEN-1:0]     r_mem [MEM_WORDS];

    logic                w_accept;
    logic                w_wait_end;
    logic                w_beat_end;
    logic [IDX_BITS-1:0] w_line_base;
    logic [IDX_BITS-1:0] w_word_addr;
    logic                w_we;
    logic                w_re;
    logic                w_cap;
    int                  w_cap_idx;

    assign w_accept    = (r_state == S_IDLE) && S_DMEM_strobe_i && !r_strobe_q;
    assign w_wait_end  = (r_cnt == CNT_W'(WAIT_CYC - 1));
    assign w_beat_end  = (r_cnt == CNT_W'(N_BEATS - 1));
    // Offset bits dropped and bits above the SRAM range truncated, so lines wrap.
    assign w_line_base = IDX_BITS'((S_DMEM_addr_i >> OFS_BITS) << BEAT_BITS);
    assign w_word_addr = r_base + IDX_BITS'(r_cnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_WAIT;
            S_WAIT:   if (w_wait_end) w_next = S_XFER;
            S_XFER:   if (w_beat_end) w_next = r_rw ? S_DONE : S_RDLAST;
            S_RDLAST: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        S_DMEM_done_o = (r_state == S_DONE);
        busy_o        = (r_state != S_IDLE);
        // Reset in the same cycle as a write beat suppresses that beat.
        w_we          = (r_state == S_XFER) && r_rw && !rst_i;
        w_re          = (r_state == S_XFER) && !r_rw;
        w_cap         = ((r_state == S_XFER) && !r_rw && (r_cnt != '0))
                        || (r_state == S_RDLAST);
        w_cap_idx     = N_BEATS - 1;
        if (r_state == S_XFER && r_cnt != '0) begin
            w_cap_idx = int'(r_cnt) - 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_strobe_q <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_strobe_q <= S_DMEM_strobe_i;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT || r_state == S_XFER) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_base  <= w_line_base;
            r_rw    <= S_DMEM_rw_i;
            r_wdata <= S_DMEM_data_i;
        end
    end

    // Single-port SRAM, synchronous read: word k arrives while beat k+1 is issued.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_word_addr] <= r_wdata[int'(r_cnt)*XLEN +: XLEN];
        end
        if (w_re) begin
            r_rdata <= r_mem[w_word_addr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdline <= '0;
        end else if (w_cap) begin
            r_rdline[w_cap_idx*XLEN +: XLEN] <= r_rdata;
        end
    end

    assign S_DMEM_data_o = r_rdline;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Bench for dmem_line_responder: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a word-array memory model.
module tb_dmem_line_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         strobe;
    logic         rw;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         done4, busy4, done0, busy0;
    logic [255:0] rd4, rd0;

    always #5 clk = ~clk;

    dmem_line_responder #(.LAT_WAIT(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .S_DMEM_strobe_i(strobe), .S_DMEM_addr_i(addr),
        .S_DMEM_rw_i(rw), .S_DMEM_data_i(wdata), .S_DMEM_done_o(done4),
        .S_DMEM_data_o(rd4), .busy_o(busy4)
    );

    dmem_line_responder #(.LAT_WAIT(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .S_DMEM_strobe_i(strobe), .S_DMEM_addr_i(addr),
        .S_DMEM_rw_i(rw), .S_DMEM_data_i(wdata), .S_DMEM_done_o(done0),
        .S_DMEM_data_o(rd0), .busy_o(busy0)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [int];

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [255:0] data;
        int           lat4;
        int           lat0;
        logic [255:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Word index in SRAM: line number times words per line, modulo depth.
    function automatic int widx(input logic [31:0] a, input int k);
        logic [31:0] w;
        w = (a / 32) * 8 + 32'(k);
        return int'(w % 16384);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [255:0] d);
        for (int k = 0; k < 8; k++) mdl[widx(a, k)] = d[k*32 +: 32];
    endtask

    task automatic model_read(input logic [31:0] a, output logic [255:0] e, output logic [255:0] m);
        e = '0;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            if (mdl.exists(widx(a, k))) begin
                e[k*32 +: 32] = mdl[widx(a, k)];
                m[k*32 +: 32] = 32'hFFFF_FFFF;
            end
        end
    endtask

    // Cycle 0 is the cycle in which the rising strobe is presented; lat is the
    // index of the first cycle in which done is high (-1 if never seen).
    task automatic xact(input logic r_w, input logic [31:0] a, input logic [255:0] d,
                        output int lat4, output int lat0, output int wid4,
                        output logic [255:0] rdv);
        strobe = 1'b1;
        rw     = r_w;
        addr   = a;
        wdata  = d;
        lat4   = -1;
        lat0   = -1;
        wid4   = 0;
        rdv    = '0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done4) begin
                if (lat4 < 0) begin
                    lat4 = n;
                    rdv  = rd4;
                end
                wid4++;
            end
            if (done0 && lat0 < 0) lat0 = n;
            if (lat4 >= 0 && n >= lat4 + 2) break;
        end
        strobe = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [255:0] p1, p2, a5, rdv, e, m;
    int l4, l0, w4, cnt, lat;

    initial begin
        for (int k = 0; k < 8; k++) begin
            p1[k*32 +: 32] = 32'h1111_1111 * 32'(k + 1);
            p2[k*32 +: 32] = 32'hDEAD_0000 + 32'(k * 16'h0101);
        end
        a5 = {8{32'hA5A5_A5A5}};

        tbl[0] = '{1'b1, 32'h8000_0040, p1,   13, 10, '0};
        tbl[1] = '{1'b0, 32'h8000_0040, '0,   14, 11, p1};
        tbl[2] = '{1'b1, 32'h8000_0000, p2,   13, 10, '0};
        tbl[3] = '{1'b0, 32'h8001_0000, '0,   14, 11, p2};
        tbl[4] = '{1'b0, 32'h8000_001C, '0,   14, 11, p2};
        tbl[5] = '{1'b1, 32'h0000_0100, '0,   13, 10, '0};

        rst = 1'b1; strobe = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_done4", 256'(done4), 256'(0));
        chk("reset_busy4", 256'(busy4), 256'(0));
        chk("reset_data4", rd4, '0);
        chk("reset_done0", 256'(done0), 256'(0));
        chk("reset_busy0", 256'(busy0), 256'(0));
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            xact(tbl[i].rw, tbl[i].addr, tbl[i].data, l4, l0, w4, rdv);
            chk_int($sformatf("tbl%0d_lat4", i), l4, tbl[i].lat4);
            chk_int($sformatf("tbl%0d_lat0", i), l0, tbl[i].lat0);
            chk_int($sformatf("tbl%0d_width", i), w4, 1);
            if (tbl[i].rw) model_write(tbl[i].addr, tbl[i].data);
            else chk($sformatf("tbl%0d_data", i), rdv, tbl[i].exp);
        end

        // Strobe held long after done must not re-trigger.
        strobe = 1'b1; rw = 1'b0; addr = 32'h8000_0040;
        cnt = 0;
        for (int n = 1; n <= 54; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done4) cnt++;
        end
        chk_int("hold_pulses", cnt, 1);
        strobe = 1'b0;
        @(posedge clk);
        @(negedge clk);
        strobe = 1'b1;
        cnt = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done4) cnt++;
        end
        chk_int("rearm_pulses", cnt, 1);
        chk("rearm_data", rd4, p1);
        strobe = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset during write beat 3 (cycle 8 with a 4-cycle wait).
        strobe = 1'b1; rw = 1'b1; addr = 32'h0000_0100; wdata = a5;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_busy_before", 256'(busy4), 256'(1));
        rst = 1'b1;
        strobe = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", 256'(done4), 256'(0));
        chk("abort_busy", 256'(busy4), 256'(0));
        chk("abort_data", rd4, '0);
        cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done4 || done0) cnt++;
        end
        chk_int("abort_no_pulse", cnt, 0);
        for (int k = 0; k < 3; k++) mdl[widx(32'h100, k)] = 32'hA5A5_A5A5;
        mdl.delete(widx(32'h100, 3));
        xact(1'b0, 32'h0000_0100, '0, l4, l0, w4, rdv);
        chk_int("abort_read_lat", l4, 14);
        chk("abort_words_0_2", 256'(rdv[95:0]), 256'({3{32'hA5A5_A5A5}}));
        chk("abort_words_4_7", 256'(rdv[255:128]), '0);

        // Second strobe rise during XFER must be ignored.
        strobe = 1'b1; rw = 1'b0; addr = 32'h8000_0040;
        cnt = 0; lat = -1; rdv = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 6) strobe = 1'b0;
            if (n == 7) strobe = 1'b1;
            if (done4) begin
                cnt++;
                if (lat < 0) begin
                    lat = n;
                    rdv = rd4;
                end
            end
        end
        chk_int("busy_rise_pulses", cnt, 1);
        chk_int("busy_rise_lat", lat, 14);
        chk("busy_rise_data", rdv, p1);
        strobe = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Randomized traffic over 16 lines with random high and offset bits.
        for (int i = 0; i < 40; i++) begin
            logic         rrw;
            logic [31:0]  ra;
            logic [255:0] rd;
            int           line;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                @(negedge clk);
            end
            rrw  = 1'($urandom % 2);
            line = $urandom_range(0, 15);
            ra   = ($urandom & 32'hFFFF_001F) | (32'(line) << 5);
            for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom;
            xact(rrw, ra, rd, l4, l0, w4, rdv);
            chk_int($sformatf("rnd%0d_lat4", i), l4, rrw ? 13 : 14);
            chk_int($sformatf("rnd%0d_lat0", i), l0, rrw ? 10 : 11);
            if (rrw) begin
                model_write(ra, rd);
            end else begin
                model_read(ra, e, m);
                chk($sformatf("rnd%0d_data", i), rdv & m, e & m);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
